// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register file with per-register busy scoreboard and write-back bypass.
// Address REG_AMT selects the immediate on reads and means "no register" for destinations.
module rf_scoreboard #(
   parameter int DATA_WIDTH = 8,
   parameter int REG_AMT    = 4,
   parameter int RD_PORTS   = 2,
   parameter int AW         = $clog2(REG_AMT + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           iss_vld,
   input  logic [RD_PORTS*AW-1:0]         iss_src,
   input  logic [AW-1:0]                  iss_dst,
   input  logic [DATA_WIDTH-1:0]          iss_imm,
   output logic                           iss_rdy,
   output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
   input  logic                           wb_vld,
   input  logic [AW-1:0]                  wb_dst,
   input  logic [DATA_WIDTH-1:0]          wb_data,
   output logic [REG_AMT-1:0]             busy,
   output logic [$clog2(REG_AMT+1)-1:0]   pending
);
   localparam int PW = $clog2(REG_AMT + 1);
   localparam logic [AW-1:0] IMM = AW'(REG_AMT);
   logic [DATA_WIDTH-1:0] regs [REG_AMT];
   logic [REG_AMT-1:0] set_v, clr_v, busy_nxt;
   logic [RD_PORTS-1:0] src_haz;
   logic dst_haz;
   logic [PW-1:0] pending_nxt;
   // Address decode by loop keeps out-of-range addresses (IMM and above) harmless.
   always_comb begin
      clr_v = '0;
      set_v = '0;
      src_haz = '0;
      dst_haz = 1'b0;
      rd_data = '0;
      pending_nxt = '0;
      for (int i = 0; i < REG_AMT; i++) begin
         clr_v[i] = wb_vld && wb_dst == AW'(i);
         if (iss_dst == AW'(i)) dst_haz = busy[i] && !clr_v[i];
      end
      for (int p = 0; p < RD_PORTS; p++) begin
         if (iss_src[p*AW +: AW] == IMM) rd_data[p*DATA_WIDTH +: DATA_WIDTH] = iss_imm;
         for (int i = 0; i < REG_AMT; i++) begin
            if (iss_src[p*AW +: AW] == AW'(i)) begin
               rd_data[p*DATA_WIDTH +: DATA_WIDTH] = clr_v[i] ? wb_data : regs[i];
               src_haz[p] = busy[i] && !clr_v[i];
            end
         end
      end
      iss_rdy = iss_vld && !dst_haz && ~|src_haz;
      for (int i = 0; i < REG_AMT; i++) set_v[i] = iss_rdy && iss_dst == AW'(i);
      busy_nxt = (busy & ~clr_v) | set_v;
      for (int i = 0; i < REG_AMT; i++) pending_nxt = pending_nxt + PW'(busy_nxt[i]);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
         pending <= '0;
         for (int i = 0; i < REG_AMT; i++) regs[i] <= '0;
      end else begin
         busy <= busy_nxt;
         pending <= pending_nxt;
         for (int i = 0; i < REG_AMT; i++) if (clr_v[i]) regs[i] <= wb_data;
      end
   end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed and random stimulus against an array-based reference model;
// expectations are queued by the driver and compared by an independent negedge monitor.
module tb_rf_scoreboard;
   localparam int DW = 8;
   localparam int RA = 4;
   localparam int RP = 2;
   localparam int AW = $clog2(RA + 1);
   localparam int PW = $clog2(RA + 1);
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic iss_vld = 1'b0;
   logic [RP*AW-1:0] iss_src = '0;
   logic [AW-1:0] iss_dst = '0;
   logic [DW-1:0] iss_imm = '0;
   logic iss_rdy;
   logic [RP*DW-1:0] rd_data;
   logic wb_vld = 1'b0;
   logic [AW-1:0] wb_dst = '0;
   logic [DW-1:0] wb_data = '0;
   logic [RA-1:0] busy;
   logic [PW-1:0] pending;
   typedef struct {
      logic rdy;
      logic [RP*DW-1:0] rd;
      logic [RA-1:0] busy;
      logic [PW-1:0] pend;
   } exp_t;
   exp_t q[$];
   logic [DW-1:0] m_regs [RA];
   bit m_busy [RA];
   int checks = 0;
   int errors = 0;
   rf_scoreboard #(.DATA_WIDTH(DW), .REG_AMT(RA), .RD_PORTS(RP), .AW(AW)) dut (
      .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_src(iss_src), .iss_dst(iss_dst),
      .iss_imm(iss_imm), .iss_rdy(iss_rdy), .rd_data(rd_data), .wb_vld(wb_vld),
      .wb_dst(wb_dst), .wb_data(wb_data), .busy(busy), .pending(pending)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("iss_rdy", 128'(iss_rdy), 128'(e.rdy));
            chk("rd_data", 128'(rd_data), 128'(e.rd));
            chk("busy", 128'(busy), 128'(e.busy));
            chk("pending", 128'(pending), 128'(e.pend));
         end
      end
   end
   function automatic logic [RP*AW-1:0] mk(input int a0, input int a1);
      logic [RP*AW-1:0] v;
      v = '0;
      for (int p = 0; p < RP; p++) v[p*AW +: AW] = AW'(p == 0 ? a0 : a1);
      return v;
   endfunction
   task automatic model_clear();
      for (int i = 0; i < RA; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask
   // Called just after a rising edge: drive one cycle, queue its expectation, advance the model.
   task automatic drive(input bit vld, input logic [RP*AW-1:0] src, input int dst,
                        input logic [DW-1:0] imm, input bit wv, input int wd,
                        input logic [DW-1:0] wdat);
      exp_t e;
      bit haz;
      int s;
      int cnt;
      iss_vld = vld;
      iss_src = src;
      iss_dst = AW'(dst);
      iss_imm = imm;
      wb_vld = wv;
      wb_dst = AW'(wd);
      wb_data = wdat;
      haz = 1'b0;
      e.rd = '0;
      for (int p = 0; p < RP; p++) begin
         s = int'(src[p*AW +: AW]);
         if (s == RA) e.rd[p*DW +: DW] = imm;
         else if (s < RA && wv && wd == s) e.rd[p*DW +: DW] = wdat;
         else if (s < RA) e.rd[p*DW +: DW] = m_regs[s];
         if (s < RA && m_busy[s] && !(wv && wd == s)) haz = 1'b1;
      end
      if (dst < RA && m_busy[dst] && !(wv && wd == dst)) haz = 1'b1;
      e.rdy = vld && !haz;
      cnt = 0;
      for (int i = 0; i < RA; i++) begin
         e.busy[i] = m_busy[i];
         cnt += int'(m_busy[i]);
      end
      e.pend = PW'(cnt);
      q.push_back(e);
      @(posedge clk);
      #1;
      if (!rst) begin
         if (wv && wd < RA) begin
            m_regs[wd] = wdat;
            m_busy[wd] = 1'b0;
         end
         if (e.rdy && dst < RA) m_busy[dst] = 1'b1;
      end
   endtask
   task automatic idle();
      drive(0, mk(RA, RA), RA, '0, 0, RA, '0);
   endtask
   initial begin
      int n;
      model_clear();
      @(posedge clk);
      #1;
      drive(1, mk(0, 1), RA, 8'h00, 0, 0, 8'h00);
      rst = 1'b0;
      drive(0, mk(RA, RA), RA, 8'h00, 1, 2, 8'hA5);
      drive(1, mk(2, 2), RA, 8'h00, 0, 0, 8'h00);
      drive(0, mk(RA, RA), RA, 8'h00, 1, 1, 8'h11);
      drive(1, mk(1, RA), RA, 8'h3C, 0, 0, 8'h00);
      drive(1, mk(RA, RA), 1, 8'h00, 0, 0, 8'h00);
      drive(1, mk(1, 1), RA, 8'h00, 0, 0, 8'h00);
      drive(1, mk(1, 1), RA, 8'h00, 1, 1, 8'h7E);
      drive(1, mk(RA, RA), 3, 8'h00, 0, 0, 8'h00);
      drive(1, mk(RA, RA), 3, 8'h00, 0, 0, 8'h00);
      drive(1, mk(RA, RA), 3, 8'h00, 1, 3, 8'h5A);
      drive(0, mk(3, 3), RA, 8'h00, 1, RA, 8'hFF);
      drive(0, mk(3, RA), RA, 8'h00, 1, 3, 8'h66);
      for (int i = 0; i < RA; i++) drive(1, mk(RA, RA), i, 8'h00, 0, 0, 8'h00);
      idle();
      drive(0, mk(RA, RA), RA, 8'h00, 1, 2, 8'h22);
      drive(0, mk(RA, RA), RA, 8'h00, 1, 0, 8'h20);
      drive(0, mk(RA, RA), RA, 8'h00, 1, 3, 8'h23);
      drive(0, mk(RA, RA), RA, 8'h00, 1, 1, 8'h21);
      drive(0, mk(RA, RA), RA, 8'h00, 1, 1, 8'h31);
      drive(1, mk(0, 1), 2, 8'h00, 0, 0, 8'h00);
      drive(1, mk(RA, RA), 0, 8'h00, 0, 0, 8'h00);
      #2;
      rst = 1'b1;
      model_clear();
      drive(1, mk(2, 0), 1, 8'h00, 1, 3, 8'hEE);
      rst = 1'b0;
      drive(1, mk(3, 1), RA, 8'h00, 0, 0, 8'h00);
      for (int k = 0; k < 400; k++)
         drive($urandom_range(0, 1), mk($urandom_range(0, RA), $urandom_range(0, RA)),
               $urandom_range(0, RA), DW'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, RA), DW'($urandom));
      idle();
      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d queued expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the pipelined microcontroller, with a per-register busy scoreboard and write-back bypass. It sits between decode and execute. Decode presents source/destination addresses at issue; the block returns operands, flags hazards, and stalls issue until they clear. Write-back retires results into the array and clears busy bits. It generalises the fixed 8-bit, 4-register, R0–R3/IMM register naming to any width, depth and read-port count.

## Interface
Parameters:
- DATA_WIDTH, 8, operand/register width
- REG_AMT, 4, number of general-purpose registers (R0..R(REG_AMT-1))
- RD_PORTS, 2, number of source operand ports
- AW, $clog2(REG_AMT+1), address width; address value REG_AMT encodes IMM

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- iss_vld  in  1  decode presents an instruction this cycle
- iss_src  in  RD_PORTS×AW  source addresses, one per port
- iss_dst  in  AW  destination address; REG_AMT (IMM) means no destination
- iss_imm  in  DATA_WIDTH  immediate value returned for any source addressed IMM
- iss_rdy  out  1  instruction accepted this cycle (combinational)
- rd_data  out  RD_PORTS×DATA_WIDTH  operand values (combinational)
- wb_vld  in  1  write-back valid
- wb_dst  in  AW  write-back register
- wb_data  in  DATA_WIDTH  write-back value
- busy  out  REG_AMT  registered scoreboard bits, bit i = Ri pending
- pending  out  $clog2(REG_AMT+1)  count of set busy bits, registered

## Operation
- Operand read, per port p:
  - If iss_src[p] == REG_AMT: iss_imm.
  - Else if wb_vld and wb_dst == iss_src[p]: wb_data (bypass).
  - Else: the array entry.
- Source hazard on port p: iss_src[p] < REG_AMT, busy[iss_src[p]] = 1, and not bypassed this cycle.
- Destination hazard (WAW): iss_dst < REG_AMT, busy[iss_dst] = 1, and not (wb_vld and wb_dst == iss_dst).
- iss_rdy = iss_vld & no source hazard & no destination hazard.
- On an accepted issue with iss_dst < REG_AMT, busy[iss_dst] sets at the next edge.
- wb_vld with wb_dst < REG_AMT:
  - Writes wb_data into the array at the next edge.
  - Clears busy[wb_dst] at the next edge.
- wb_dst == REG_AMT or wb_dst > REG_AMT is ignored: no write, no busy change.
- Same-register issue and write-back in one cycle: the write occurs and busy ends **set** (set wins over clear).
- A write-back to a non-busy register is still written. busy is unchanged and pending does not underflow.
- pending is updated each edge to the popcount of the next busy vector; it never exceeds REG_AMT.
- Issue when iss_vld = 0: no state change, iss_rdy = 0. rd_data remains valid.

## Timing
- Reset, asynchronous:
  - Array, busy and pending clear to 0 immediately.
  - Outputs: busy = 0 and pending = 0. iss_rdy reflects inputs combinationally (1 if iss_vld).
  - rd_data reads 0 for register addresses.
- Reset asserted mid-operation discards all pending writes. Write-backs arriving while rst is high are dropped.
- Read latency: 0 cycles (combinational). A write is visible through bypass in the same cycle and from the array on the next cycle.
- Issue-to-busy: 1 cycle. Write-back-to-busy-clear: 1 cycle.
- A stalled instruction must be held stable by decode until iss_rdy = 1. The block keeps no state for unaccepted issues.

## Test plan
- Reset/readback:
  - Assert rst mid-run → busy = 0, pending = 0, all reads return 0.
  - Write 8'hA5 to R2, then read R2 on both ports next cycle → 8'hA5 on both.
- IMM path: iss_src = {IMM, R1}, iss_imm = 8'h3C, R1 = 8'h11 → rd_data = {8'h3C, 8'h11}, iss_rdy = 1.
- RAW stall and bypass:
  - Issue dst R1, then next cycle issue src R1 with no write-back → iss_rdy = 0.
  - Apply wb R1 = 8'h7E in that cycle → iss_rdy = 1, rd_data = 8'h7E.
- WAW: R3 busy, issue dst R3 → iss_rdy = 0. Same cycle wb R3 → accepted; next cycle busy[3] = 1, array R3 = wb value.
- Scoreboard full:
  - Issue dst R0..R3 on consecutive cycles → pending = 1, 2, 3, 4.
  - Write-back all four in any order → pending counts down to 0, never wraps.
- Parametrisation: rerun the above with DATA_WIDTH = 16, REG_AMT = 8, RD_PORTS = 3. IMM address = 8 is ignored on write-back.
